serial_subtract_ctrl: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/bit_sub_cell.sv | 19 +
 rtl/serial_subtract_ctrl.sv | 113 +++++++++++
 tb/tb_serial_subtract_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the serial subtractor controller.
package serial_sub_pkg;

    // Controller states: waiting, shifting bits through the cell, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // A - B is computed as A + ~B + 1, so the chain starts with carry set.
    localparam logic CARRY_INIT = 1'b1;

endpackage

// File: rtl/bit_sub_cell.sv
// Combinational 1-bit subtractor cell: adds a, the inverted b and a carry-in.
module bit_sub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic d,
    output logic cout
);

    logic nb;

    // Two's-complement subtraction bit: sum and majority carry of (a, ~b, cin).
    always_comb begin
        nb   = ~b;
        d    = a ^ nb ^ cin;
        cout = (a & nb) | (a & cin) | (nb & cin);
    end

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial unsigned subtractor: one shared cell stepped LSB first over
// WIDTH cycles, with a start/busy/done handshake and a held result.
module serial_subtract_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    sub_state_t       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_reg, borrow_next;
    logic             carry_reg, carry_next;
    logic [IDX_W-1:0] idx_reg, idx_next;

    logic cell_d;
    logic cell_cout;

    // The single arithmetic cell; the controller owns every register around it.
    bit_sub_cell u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .d    (cell_d),
        .cout (cell_cout)
    );

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            carry_reg  <= CARRY_INIT;
            idx_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            carry_reg  <= carry_next;
            idx_reg    <= idx_next;
        end
    end

    // Next-state and datapath update: accept in IDLE/DONE, shift one bit per RUN cycle.
    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        carry_next  = carry_reg;
        idx_next    = idx_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    // Operands are latched here, so later input changes are invisible.
                    a_next     = a_in;
                    b_next     = b_in;
                    carry_next = CARRY_INIT;
                    idx_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so after WIDTH steps bit 0 lands at diff[0].
                diff_next  = {cell_d, diff_reg[WIDTH-1:1]};
                a_next     = a_reg >> 1;
                b_next     = b_reg >> 1;
                carry_next = cell_cout;
                idx_next   = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    // No final carry out of A + ~B + 1 means A < B.
                    borrow_next = ~cell_cout;
                    state_next  = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and result outputs decode directly from registers.
    always_comb begin
        busy   = (state_reg == RUN);
        done   = (state_reg == DONE);
        diff   = diff_reg;
        borrow = borrow_reg;
    end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl at WIDTH=8.
module tb_serial_subtract_ctrl;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int n_total;
    int n_pass;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bw;
    } vec_t;

    vec_t vecs[8];

    serial_subtract_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers.
    function automatic int ref_diff(input int a, input int b);
        return (a - b + 256) % 256;
    endfunction

    function automatic int ref_borrow(input int a, input int b);
        return (a < b) ? 1 : 0;
    endfunction

    // Called at a negedge right after start has been driven for the accepting edge.
    // Counts negedges until done, bounded; optionally drops start and pulses it mid-run.
    task automatic wait_done(input bit drop, input logic [7:0] na, input logic [7:0] nb,
                             input int pulse_at, output int cyc, output int bc, output int ov);
        cyc = -1;
        bc  = 0;
        ov  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a_in = na;
                b_in = nb;
                if (drop) start = 1'b0;
            end
            if (pulse_at > 0 && i == pulse_at) begin
                start = 1'b1;
                a_in  = 8'($urandom_range(0, 255));
                b_in  = 8'($urandom_range(0, 255));
            end
            if (pulse_at > 0 && i == pulse_at + 1) start = 1'b0;
            if (busy && done) ov++;
            if (done) begin
                cyc = i;
                break;
            end
            if (busy) bc++;
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input int exp_d, input int exp_bw, input string tag);
        int cyc, bc, ov;
        logic [7:0] held;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        wait_done(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, cyc, bc, ov);
        chk({tag, " latency"}, cyc, LAT);
        chk({tag, " busy cycles"}, bc, WIDTH);
        chk({tag, " busy&done overlap"}, ov, 0);
        chk({tag, " diff"}, int'(diff), exp_d);
        chk({tag, " borrow"}, int'(borrow), exp_bw);
        $display("op %s: a=%0d b=%0d -> diff=%0d borrow=%0d (exp %0d/%0d) lat=%0d",
                 tag, a, b, diff, borrow, exp_d, exp_bw, cyc);
        held = diff;
        @(negedge clk);
        chk({tag, " done one cycle"}, int'(done), 0);
        chk({tag, " diff held"}, int'(diff), int'(held));
    endtask

    initial begin
        int cyc, bc, ov, seen;
        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{a: 8'd200, b: 8'd55,  d: 8'd145, bw: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd9,   d: 8'hFC,  bw: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd1,   d: 8'hFF,  bw: 1'b1};
        vecs[3] = '{a: 8'h3C,  b: 8'h3C,  d: 8'h00,  bw: 1'b0};
        vecs[4] = '{a: 8'd255, b: 8'd0,   d: 8'd255, bw: 1'b0};
        vecs[5] = '{a: 8'd0,   b: 8'd255, d: 8'd1,   bw: 1'b1};
        vecs[6] = '{a: 8'd128, b: 8'd127, d: 8'd1,   bw: 1'b0};
        vecs[7] = '{a: 8'd127, b: 8'd128, d: 8'd255, bw: 1'b1};

        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset diff", int'(diff), 0);
        chk("reset borrow", int'(borrow), 0);
        $display("reset: busy=%0d done=%0d diff=%0d borrow=%0d", busy, done, diff, borrow);
        reset = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, int'(vecs[i].d), int'(vecs[i].bw), $sformatf("vec%0d", i));
        end

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, ref_diff(int'(ra), int'(rb)), ref_borrow(int'(ra), int'(rb)),
                  $sformatf("rnd%0d", i));
        end

        // start pulsed on RUN cycle 3 with other operands is ignored.
        start = 1'b1;
        a_in  = 8'h50;
        b_in  = 8'h20;
        wait_done(1'b1, 8'h11, 8'h22, 3, cyc, bc, ov);
        chk("ignored-start latency", cyc, LAT);
        chk("ignored-start diff", int'(diff), 8'h30);
        chk("ignored-start borrow", int'(borrow), 0);
        $display("op ignored-start: a=80 b=32 -> diff=%0d borrow=%0d lat=%0d", diff, borrow, cyc);
        @(negedge clk);
        chk("ignored-start back to idle", int'(busy), 0);

        // start held through done: second op follows with no bubble.
        start = 1'b1;
        a_in  = 8'd30;
        b_in  = 8'd12;
        wait_done(1'b0, 8'd100, 8'd1, 0, cyc, bc, ov);
        chk("b2b first latency", cyc, LAT);
        chk("b2b first diff", int'(diff), 18);
        $display("op b2b-1: a=30 b=12 -> diff=%0d borrow=%0d lat=%0d", diff, borrow, cyc);
        wait_done(1'b1, 8'd7, 8'd7, 0, cyc, bc, ov);
        chk("b2b second spacing", cyc, LAT);
        chk("b2b second busy cycles", bc, WIDTH);
        chk("b2b second diff", int'(diff), 99);
        chk("b2b second borrow", int'(borrow), 0);
        $display("op b2b-2: a=100 b=1 -> diff=%0d borrow=%0d lat=%0d", diff, borrow, cyc);
        @(negedge clk);

        // Reset on RUN cycle 4 abandons the operation.
        start = 1'b1;
        a_in  = 8'd77;
        b_in  = 8'd20;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrun reset busy", int'(busy), 0);
        chk("midrun reset done", int'(done), 0);
        chk("midrun reset diff", int'(diff), 0);
        chk("midrun reset borrow", int'(borrow), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("midrun reset no done", seen, 0);
        $display("op midrun-reset: a=77 b=20 -> abandoned, activity after reset=%0d", seen);
        do_op(8'd10, 8'd3, 7, 0, "after-reset");

        // reset and start together in IDLE: reset wins.
        reset = 1'b1;
        start = 1'b1;
        a_in  = 8'd9;
        b_in  = 8'd4;
        @(negedge clk);
        chk("reset+start busy", int'(busy), 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("reset+start still idle", int'(busy), 0);
        chk("reset+start no done", int'(done), 0);
        $display("op reset+start: busy=%0d done=%0d", busy, done);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
